// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: circular ADC sample buffer with level/edge trigger and a frozen, trigger-aligned read window.
// Optional forced trigger after AUTO_TIMEOUT armed samples when ADC_CAPTURE_AUTOTRIG_EN is defined.
module adc_capture_ctrl #(
  parameter int DEPTH        = 512,
  parameter int AW           = 9,
  parameter int PRETRIG      = 128,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          abort,
  input  logic [1:0]    ch_sel,
  input  logic [11:0]   trig_level,
  input  logic          trig_falling,
  input  logic          sample_valid,
  input  logic [11:0]   sample_data,
  output logic [1:0]    adc_channel,
  output logic          busy,
  output logic          triggered,
  output logic          done,
  output logic          trig_forced,
  input  logic [AW-1:0] rd_addr,
  output logic [11:0]   rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } state_t;

  localparam int            POST_LEN  = DEPTH - PRETRIG;
  localparam logic [AW-1:0] PRETRIG_A = AW'(PRETRIG);

  // Parameter legality is checked at elaboration so a bad build never reaches the board.
  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("adc_capture_ctrl: DEPTH must equal 2**AW");
  end
  if (DEPTH < 8) begin : g_small_depth
    $error("adc_capture_ctrl: DEPTH must be at least 8");
  end
  if (PRETRIG < 1 || PRETRIG > DEPTH - 2) begin : g_bad_pretrig
    $error("adc_capture_ctrl: PRETRIG must lie in 1..DEPTH-2");
  end
  if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
    $error("adc_capture_ctrl: AUTO_TIMEOUT must be positive");
  end

  state_t          state_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   trig_ptr_reg;
  logic [AW-1:0]   pre_cnt_reg;
  logic [AW-1:0]   post_cnt_reg;
  logic [11:0]     level_reg;
  logic            falling_reg;
  logic [11:0]     prev_reg;
  logic            have_prev_reg;

  logic [11:0]     mem [DEPTH];

  logic            capturing;
  logic            take;
  logic            rearm;
  logic [AW:0]     pre_cnt_inc;
  logic [AW:0]     post_cnt_inc;
  logic            rise_hit;
  logic            fall_hit;
  logic            edge_hit;
  logic            timeout_hit;
  logic [AW-1:0]   rd_ptr;

  assign capturing = (state_reg == ST_PRETRIG) || (state_reg == ST_ARMED) ||
                     (state_reg == ST_POST);
  assign take      = capturing && sample_valid && !abort;
  assign rearm     = arm && !abort && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  assign pre_cnt_inc  = {1'b0, pre_cnt_reg}  + (AW+1)'(1);
  assign post_cnt_inc = {1'b0, post_cnt_reg} + (AW+1)'(1);

  // Edge detection compares the previous written sample against the current one.
  assign rise_hit = (prev_reg < level_reg) && (sample_data >= level_reg);
  assign fall_hit = (prev_reg > level_reg) && (sample_data <= level_reg);
  assign edge_hit = take && (state_reg == ST_ARMED) && have_prev_reg &&
                    (falling_reg ? fall_hit : rise_hit);

`ifdef ADC_CAPTURE_AUTOTRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);

  logic [TW-1:0] to_cnt_reg;
  logic [TW:0]   to_cnt_inc;

  assign to_cnt_inc  = {1'b0, to_cnt_reg} + (TW+1)'(1);
  assign timeout_hit = take && (state_reg == ST_ARMED) &&
                       (to_cnt_inc == (TW+1)'(AUTO_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (rearm) begin
      to_cnt_reg <= '0;
    end else if (take && (state_reg == ST_ARMED)) begin
      to_cnt_reg <= to_cnt_inc[TW-1:0];
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      trig_ptr_reg  <= '0;
      pre_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      level_reg     <= '0;
      falling_reg   <= 1'b0;
      prev_reg      <= '0;
      have_prev_reg <= 1'b0;
      adc_channel   <= '0;
      busy          <= 1'b0;
      triggered     <= 1'b0;
      done          <= 1'b0;
      trig_forced   <= 1'b0;
    end else if (abort) begin
      // Channel selection is deliberately kept so the ADC reader is not disturbed.
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      triggered <= 1'b0;
    end else if (rearm) begin
      state_reg     <= ST_PRETRIG;
      adc_channel   <= ch_sel;
      level_reg     <= trig_level;
      falling_reg   <= trig_falling;
      wr_ptr_reg    <= '0;
      pre_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      have_prev_reg <= 1'b0;
      triggered     <= 1'b0;
      done          <= 1'b0;
      trig_forced   <= 1'b0;
      busy          <= 1'b1;
    end else if (take) begin
      wr_ptr_reg    <= wr_ptr_reg + AW'(1);
      prev_reg      <= sample_data;
      have_prev_reg <= 1'b1;
      case (state_reg)
        ST_PRETRIG: begin
          pre_cnt_reg <= pre_cnt_inc[AW-1:0];
          if (pre_cnt_inc == (AW+1)'(PRETRIG)) begin
            state_reg <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (edge_hit || timeout_hit) begin
            trig_ptr_reg <= wr_ptr_reg;
            post_cnt_reg <= AW'(1);
            triggered    <= 1'b1;
            trig_forced  <= !edge_hit;
            state_reg    <= ST_POST;
          end
        end
        ST_POST: begin
          post_cnt_reg <= post_cnt_inc[AW-1:0];
          if (post_cnt_inc == (AW+1)'(POST_LEN)) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      mem[wr_ptr_reg] <= sample_data;
    end
  end

  // Window index 0 maps to the oldest retained pre-trigger sample; AW-bit arithmetic wraps the ring.
  assign rd_ptr = trig_ptr_reg - PRETRIG_A + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_ptr];
    end
  end

endmodule
